// File: rtl/axis_decouple_controller_pkg.sv
// Shared types and default sizing for the AXI-Stream decouple controller.
package axis_decouple_controller_pkg;

    // Controller FSM; the encodings are visible on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FORCE = 2'd2,
        ST_DONE  = 2'd3
    } dec_ctrl_state_t;

    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_TIMEOUT_WIDTH = 16;
    localparam int DEF_FCOUNT_WIDTH  = 16;

endpackage

// File: rtl/decouple_timeout_counter.sv
// Drain-timeout counter: clears on DRAIN entry, counts while draining,
// saturates at all ones and flags when the drain budget is used up.
module decouple_timeout_counter
    import axis_decouple_controller_pkg::*;
#(
    parameter int WIDTH = DEF_TIMEOUT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    // Count drain cycles, holding at all ones so a lowered limit never wraps into a match.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // A zero limit disables forcing; otherwise expire in the last budgeted cycle.
    assign o_expired = (i_limit != '0) && (r_count == (i_limit - WIDTH'(1)));

endmodule

// File: rtl/axis_decouple_controller.sv
// Sequences a bank of master-stream decouplers: request passive isolation,
// wait for every channel to report decoupled, and force stragglers once the
// drain budget runs out.
module axis_decouple_controller
    import axis_decouple_controller_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH,
    parameter int FCOUNT_WIDTH  = DEF_FCOUNT_WIDTH
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     decouple_req,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic [NUM_CH-1:0]        ch_decoupled,
    output logic [NUM_CH-1:0]        ch_decouple,
    output logic [NUM_CH-1:0]        ch_decouple_force,
    output logic                     decouple_done,
    output logic                     decouple_forced,
    output logic [FCOUNT_WIDTH-1:0]  force_count,
    output logic [1:0]               state
);

    dec_ctrl_state_t           r_state;
    dec_ctrl_state_t           w_next_state;
    logic [NUM_CH-1:0]         r_ch_decouple;
    logic [NUM_CH-1:0]         r_ch_force;
    logic                      r_done;
    logic                      r_forced;
    logic [FCOUNT_WIDTH-1:0]   r_fcount;
    logic                      w_all_decoupled;
    logic                      w_cnt_clear;
    logic                      w_cnt_enable;
    logic                      w_expired;

    assign w_all_decoupled = &ch_decoupled;

    decouple_timeout_counter #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_timeout (
        .i_clk     (aclk),
        .i_rst     (areset),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .i_limit   (timeout_cycles),
        .o_expired (w_expired)
    );

    // Next-state selection; dropping the request wins from any state.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_next_state = r_state;
        if (!decouple_req) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_DRAIN;
                ST_DRAIN: begin
                    if (w_all_decoupled) begin
                        w_next_state = ST_DONE;
                    end else if (w_expired) begin
                        w_next_state = ST_FORCE;
                    end
                end
                ST_FORCE: if (w_all_decoupled) w_next_state = ST_DONE;
                ST_DONE:  if (!w_all_decoupled) w_next_state = ST_DRAIN;
                default:  w_next_state = ST_IDLE;
            endcase
        end
        // Every DRAIN entry (from IDLE or DONE) restarts the drain budget.
        w_cnt_clear  = (w_next_state == ST_DRAIN) && (r_state != ST_DRAIN);
        w_cnt_enable = (r_state == ST_DRAIN);
    end

    // State and registered outputs, all computed from the upcoming state.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= ST_IDLE;
            r_ch_decouple <= '0;
            r_ch_force    <= '0;
            r_done        <= 1'b0;
            r_forced      <= 1'b0;
            r_fcount      <= '0;
        end else begin
            r_state       <= w_next_state;
            r_ch_decouple <= (w_next_state != ST_IDLE)  ? '1 : '0;
            r_ch_force    <= (w_next_state == ST_FORCE) ? ~ch_decoupled : '0;
            r_done        <= (w_next_state == ST_DONE);
            // The forced flag spans one episode: cleared only by a fresh request.
            if ((r_state == ST_IDLE) && (w_next_state == ST_DRAIN)) begin
                r_forced <= 1'b0;
            end else if (w_next_state == ST_FORCE) begin
                r_forced <= 1'b1;
            end
            if ((r_state == ST_FORCE) && (w_next_state == ST_DONE) && (r_fcount != '1)) begin
                r_fcount <= r_fcount + FCOUNT_WIDTH'(1);
            end
        end
    end

    assign ch_decouple       = r_ch_decouple;
    assign ch_decouple_force = r_ch_force;
    assign decouple_done     = r_done;
    assign decouple_forced   = r_forced;
    assign force_count       = r_fcount;
    assign state             = r_state;

endmodule

// File: tb/tb_axis_decouple_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the controller rules.
module tb_axis_decouple_controller;

    localparam int NC   = 4;
    localparam int TW   = 8;
    localparam int FW   = 3;
    localparam int TMAX = (1 << TW) - 1;
    localparam int FMAX = (1 << FW) - 1;

    logic          aclk = 1'b0;
    logic          areset;
    logic          decouple_req;
    logic [TW-1:0] timeout_cycles;
    logic [NC-1:0] ch_decoupled;
    logic [NC-1:0] ch_decouple;
    logic [NC-1:0] ch_decouple_force;
    logic          decouple_done;
    logic          decouple_forced;
    logic [FW-1:0] force_count;
    logic [1:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: episode phase, drain cycles elapsed, sticky flag, tally.
    int            m_phase;   // 0 idle, 1 draining, 2 forcing, 3 isolated
    int            m_age;
    bit            m_forced;
    int            m_fcount;
    logic [NC-1:0] m_force_vec;

    axis_decouple_controller #(
        .NUM_CH        (NC),
        .TIMEOUT_WIDTH (TW),
        .FCOUNT_WIDTH  (FW)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .decouple_req      (decouple_req),
        .timeout_cycles    (timeout_cycles),
        .ch_decoupled      (ch_decoupled),
        .ch_decouple       (ch_decouple),
        .ch_decouple_force (ch_decouple_force),
        .decouple_done     (decouple_done),
        .decouple_forced   (decouple_forced),
        .force_count       (force_count),
        .state             (state)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        int cnt;
        bit all_in;
        all_in = (ch_decoupled == '1);
        if (areset) begin
            m_phase = 0; m_age = 0; m_forced = 0; m_fcount = 0;
        end else if (!decouple_req) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: begin m_phase = 1; m_age = 0; m_forced = 0; end
                1: begin
                    cnt = (m_age > TMAX) ? TMAX : m_age;
                    if (all_in) m_phase = 3;
                    else if (timeout_cycles != 0 && cnt == int'(timeout_cycles) - 1) begin
                        m_phase = 2; m_forced = 1;
                    end else m_age++;
                end
                2: if (all_in) begin
                    m_phase = 3;
                    if (m_fcount < FMAX) m_fcount++;
                end
                default: if (!all_in) begin m_phase = 1; m_age = 0; end
            endcase
        end
        m_force_vec = (m_phase == 2) ? ~ch_decoupled : '0;
    endtask

    task automatic compare_all();
        check("state",       state,             m_phase);
        check("ch_decouple", ch_decouple,       (m_phase != 0) ? 32'hF : 32'h0);
        check("ch_force",    ch_decouple_force, m_force_vec);
        check("done",        decouple_done,     (m_phase == 3) ? 1 : 0);
        check("forced",      decouple_forced,   m_forced);
        check("force_count", force_count,       m_fcount);
    endtask

    // Apply inputs at the falling edge, clock once, then compare at the next falling edge.
    task automatic cycle(input logic rst, input logic req, input int tmo, input logic [NC-1:0] chd);
        areset         = rst;
        decouple_req   = req;
        timeout_cycles = TW'(tmo);
        ch_decoupled   = chd;
        @(posedge aclk);
        model_step();
        @(negedge aclk);
        compare_all();
    endtask

    initial begin
        logic          r_req;
        int            r_tmo;
        logic [NC-1:0] r_chd;

        // Reset state.
        cycle(1, 0, 0, 4'h0);
        cycle(1, 1, 5, 4'h0);
        check("reset_state", state, 0);
        check("reset_fcount", force_count, 0);

        // Clean drain: all channels report at the third DRAIN cycle.
        cycle(0, 1, 10, 4'h0);
        check("drain_entry_dec", ch_decouple, 4'hF);
        cycle(0, 1, 10, 4'h0);
        cycle(0, 1, 10, 4'h0);
        cycle(0, 1, 10, 4'hF);
        check("clean_done", decouple_done, 1);
        check("clean_nofcount", force_count, 0);
        cycle(0, 1, 10, 4'hF);
        cycle(0, 0, 10, 4'hF);

        // Timeout of 4 with channel 2 stuck.
        cycle(0, 1, 4, 4'b1011);
        for (int i = 0; i < 3; i++) cycle(0, 1, 4, 4'b1011);
        check("still_drain", state, 1);
        cycle(0, 1, 4, 4'b1011);
        check("force_state", state, 2);
        check("force_vec", ch_decouple_force, 4'b0100);
        cycle(0, 1, 4, 4'b1011);
        cycle(0, 1, 4, 4'hF);
        check("forced_done", decouple_done, 1);
        check("fcount_one", force_count, 1);
        check("forced_flag", decouple_forced, 1);

        // Channel 0 drops while isolated: counter restarts, flag held.
        cycle(0, 1, 4, 4'b1110);
        check("redrain_state", state, 1);
        check("redrain_done", decouple_done, 0);
        check("redrain_forced_held", decouple_forced, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 4, 4'b1110);
        cycle(0, 1, 4, 4'b1110);
        check("restart_force", state, 2);

        // Release during FORCE, then a fresh request clears the flag.
        cycle(0, 0, 4, 4'b1110);
        check("rel_dec", ch_decouple, 0);
        check("rel_force", ch_decouple_force, 0);
        check("rel_fcount", force_count, 1);
        cycle(0, 1, 4, 4'h0);
        check("new_ep_forced", decouple_forced, 0);

        // Timeout disabled: never force.
        for (int i = 0; i < 1000; i++) cycle(0, 1, 0, 4'h0);
        check("no_timeout_state", state, 1);
        cycle(0, 0, 0, 4'h0);

        // Budget of one cycle.
        cycle(0, 1, 1, 4'h0);
        cycle(0, 1, 1, 4'h0);
        check("tmo1_force", state, 2);
        cycle(0, 0, 1, 4'h0);

        // Limit lowered below the running count: saturate, never force.
        cycle(0, 1, 0, 4'h3);
        for (int i = 0; i < 30; i++) cycle(0, 1, 0, 4'h3);
        for (int i = 0; i < 300; i++) cycle(0, 1, 5, 4'h3);
        check("sat_no_force", state, 1);

        // Reset mid-DRAIN and mid-FORCE.
        cycle(1, 1, 5, 4'h3);
        check("rst_drain_state", state, 0);
        check("rst_drain_fcount", force_count, 0);
        cycle(0, 1, 1, 4'h0);
        cycle(0, 1, 1, 4'h0);
        cycle(1, 1, 1, 4'h0);
        check("rst_force_state", state, 0);
        check("rst_force_forced", decouple_forced, 0);

        // force_count saturation.
        for (int e = 0; e < FMAX + 2; e++) begin
            cycle(0, 1, 1, 4'h0);
            cycle(0, 1, 1, 4'h0);
            cycle(0, 1, 1, 4'hF);
            cycle(0, 0, 1, 4'hF);
        end
        check("fcount_sat", force_count, FMAX);

        // Randomized traffic.
        r_req = 1'b1; r_tmo = 3; r_chd = 4'h0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) r_req = ~r_req;
            if ($urandom_range(0, 29) == 0) r_tmo = $urandom_range(0, 12);
            case ($urandom_range(0, 7))
                0:       r_chd = 4'($urandom_range(0, 15));
                1:       r_chd = 4'hF;
                2:       r_chd = r_chd ^ 4'(1 << $urandom_range(0, 3));
                default: ;
            endcase
            cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, r_req, r_tmo, r_chd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_decouple_controller.md
AXIS_DECOUPLE_CONTROLLER -- requirements
Module: axis_decouple_controller

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4: number of controlled master-stream decoupler channels (1..32).
REQ-002 SHALL provide parameter TIMEOUT_WIDTH, default 16: width of the drain-timeout counter and the timeout_cycles port.
REQ-003 SHALL provide parameter FCOUNT_WIDTH, default 16: width of the force_count output.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 aclk  in  1  clock; all ports are synchronous to its rising edge.
REQ-006 areset  in  1  synchronous active-high reset.
REQ-007 decouple_req  in  1  level request to isolate all channels; deasserting it releases them.
REQ-008 timeout_cycles  in  TIMEOUT_WIDTH  drain budget before forcing; 0 = never force.
REQ-009 ch_decoupled  in  NUM_CH  per-channel "decoupled" status returned by each decoupler.
REQ-010 ch_decouple  out  NUM_CH  per-channel passive decouple request.
REQ-011 ch_decouple_force  out  NUM_CH  per-channel forced decouple request.
REQ-012 decouple_done  out  1  all channels isolated.
REQ-013 decouple_forced  out  1  sticky: the current episode needed force.
REQ-014 force_count  out  FCOUNT_WIDTH  saturating count of episodes that needed force.
REQ-015 state  out  2  current FSM state encoding, for debug.

Function
REQ-016 SHALL implement FSM states IDLE=0, DRAIN=1, FORCE=2, DONE=3; all outputs are registered.
REQ-017 IDLE: ch_decouple=0, ch_decouple_force=0, decouple_done=0; decouple_req=1 -> DRAIN next cycle.
REQ-018 On DRAIN entry, SHALL clear the timeout counter and decouple_forced; ch_decouple = all ones from the first DRAIN cycle (1-cycle latency from decouple_req).
REQ-019 DRAIN: the counter increments by 1 each cycle and saturates at all ones.
REQ-020 DRAIN, &ch_decoupled=1 -> DONE; this takes priority over timeout.
REQ-021 DRAIN, timeout_cycles!=0, counter==timeout_cycles-1 and not all decoupled -> FORCE.
REQ-022 FORCE: ch_decouple stays all ones; ch_decouple_force[i] = ~ch_decoupled[i], registered. decouple_forced=1.
REQ-023 FORCE: &ch_decoupled=1 -> DONE; force_count += 1 on this transition, saturating at all ones.
REQ-024 DONE: ch_decouple stays all ones; ch_decouple_force=0; decouple_done=1.
REQ-025 DONE: any ch_decoupled bit low -> DRAIN; the counter restarts and decouple_forced is held.
REQ-026 decouple_req=0 in any state -> IDLE next cycle; all outputs drop that cycle; decouple_forced and force_count are held.
REQ-027 A timeout_cycles change is sampled every cycle; a value already below the counter triggers FORCE on the next compare-equal only after the counter saturates/wraps (no wrap: saturate, so no FORCE).
REQ-028 timeout_cycles=1 SHALL enter FORCE after exactly one DRAIN cycle if not all decoupled.

Reset
REQ-029 areset=1 SHALL force IDLE, counter=0, all outputs 0, decouple_forced=0, force_count=0, including mid-DRAIN or mid-FORCE.
REQ-030 The first cycle after areset deasserts SHALL evaluate decouple_req normally.

Structure
REQ-031 A shared package SHALL hold the state enum (dec_ctrl_state_t), state encodings, and default parameter constants.
REQ-032 The timeout counter (clear, enable, saturate, compare-equal) SHALL be a sub-module named decouple_timeout_counter.

Verification
REQ-033 timeout=10; req=1; ch_decoupled goes to 1111 at DRAIN cycle 3 -> DONE; decouple_done=1 one cycle later; force never asserted; force_count=0.
REQ-034 timeout=4; ch_decoupled=1011 held -> FORCE after 4 DRAIN cycles; ch_decouple_force=0100; bit 2 rises -> DONE; force_count=1; decouple_forced=1.
REQ-035 timeout=0; ch_decoupled=0000 held for 1000 cycles -> remains in DRAIN; ch_decouple_force stays 0.
REQ-036 In FORCE, req drops -> IDLE next cycle; all ch_* outputs 0; force_count unchanged; a new req -> DRAIN with decouple_forced cleared.
REQ-037 In DONE, ch_decoupled bit 0 drops -> DRAIN; counter restarts at 0; decouple_done=0.
REQ-038 areset asserted mid-DRAIN -> next cycle: state=IDLE, all outputs 0, force_count=0.
